// File: rtl/gestor_botones_pkg.sv
// Shared types and default timing for the button manager.
// The hold-FSM state encoding lives here so top and sub-module agree on it.
package gestor_botones_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLDING = 2'd1,
        ST_FIRED   = 2'd2
    } hold_state_t;

    // Defaults assume a 50 MHz clock: 5 s long press, 0.5 s repeat delay, 0.2 s repeat period.
    localparam int unsigned DEF_LONG_PRESS_CYCLES = 250000000;
    localparam int unsigned DEF_REPEAT_DELAY      = 25000000;
    localparam int unsigned DEF_REPEAT_PERIOD     = 10000000;

endpackage

// File: rtl/gestor_botones_deteccion_larga.sv
// Long-press detector: one-cycle o_long exactly LONG_PRESS_CYCLES cycles after the press cycle.
// Latency: registered output. Backpressure: none; a held button fires once, then waits for release.
module deteccion_larga import gestor_botones_pkg::*; #(
    parameter int unsigned LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_level,
    input  logic i_press,
    output logic o_long
);

    localparam int unsigned CNT_W = $clog2(LONG_PRESS_CYCLES + 1);
    // The counter steps to LONG_PRESS_CYCLES-1 on the same edge that raises o_long.
    localparam logic [CNT_W-1:0] FIRE_AT = CNT_W'((LONG_PRESS_CYCLES >= 2) ? (LONG_PRESS_CYCLES - 2) : 0);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LONG_PRESS_CYCLES);

    hold_state_t      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_long;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_long  <= 1'b0;
        end else begin
            r_long <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_press) begin
                        r_cnt <= '0;
                        if (LONG_PRESS_CYCLES < 2) begin
                            r_state <= ST_FIRED;
                            r_long  <= 1'b1;
                        end else begin
                            r_state <= ST_HOLDING;
                        end
                    end
                end
                ST_HOLDING: begin
                    if (!i_level) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == FIRE_AT) begin
                            r_state <= ST_FIRED;
                            r_long  <= 1'b1;
                        end
                    end
                end
                ST_FIRED: begin
                    if (!i_level) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_long = r_long;

endmodule

// File: rtl/gestor_botones.sv
// Button manager: press pulses, long-press events, test-mode toggle; GESTOR_BOTONES_REPEAT_EN adds left/right auto-repeat.
// Latency: press pulses 1 cycle after the press is sampled. Backpressure: none, events are fire-and-forget.
module gestor_botones import gestor_botones_pkg::*; #(
    parameter int unsigned LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
    parameter int unsigned REPEAT_DELAY      = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD     = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic reset_db,
    input  logic test_db,
    input  logic action_db,
    input  logic cancel_db,
    input  logic left_db,
    input  logic right_db,
    output logic action_pulse,
    output logic cancel_pulse,
    output logic left_pulse,
    output logic right_pulse,
    output logic reset_long,
    output logic test_long,
    output logic test_mode
);

    if (LONG_PRESS_CYCLES == 0 || REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_bad_cfg
        $error("gestor_botones: timing parameters must be non-zero");
    end

    // Bit order: action, cancel, left, right, reset, test.
    logic [5:0] w_lvl;
    logic [5:0] w_press;
    logic [5:0] r_prev;
    logic [1:0] w_lr_ok;
    logic [1:0] w_lr_rep;
    logic       r_action_pulse, r_cancel_pulse, r_left_pulse, r_right_pulse;
    logic       r_test_mode;
    logic       w_reset_long, w_test_long;

    assign w_lvl   = {action_db, cancel_db, left_db, right_db, reset_db, test_db};
    assign w_press = w_lvl & ~r_prev;
    // [1]=left, [0]=right; a same-cycle left+right press cancels both.
    assign w_lr_ok = {w_press[3] & ~w_press[2], w_press[2] & ~w_press[3]};

    // Reset to ones so a button already held at reset release must be seen low first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_prev <= '1;
        else        r_prev <= w_lvl;
    end

`ifdef GESTOR_BOTONES_REPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] DLY_END = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] PER_END = REP_W'(REPEAT_PERIOD - 1);

    logic [1:0]       w_lr_lvl, w_lr_other, w_rep_tick;
    logic [1:0]       r_rep_act, r_rep_per;
    logic [REP_W-1:0] r_rep_cnt [2];

    assign w_lr_lvl   = {left_db, right_db};
    assign w_lr_other = {right_db, left_db};

    always_comb begin
        w_rep_tick = '0;
        for (int i = 0; i < 2; i++) begin
            w_rep_tick[i] = r_rep_act[i] & w_lr_lvl[i] &
                            (r_rep_cnt[i] == (r_rep_per[i] ? PER_END : DLY_END));
        end
    end

    // The repeat timer keeps ticking while both are held; only the pulse is masked.
    assign w_lr_rep = w_rep_tick & ~w_lr_other;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rep_act    <= '0;
            r_rep_per    <= '0;
            r_rep_cnt[0] <= '0;
            r_rep_cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_lr_ok[i]) begin
                    r_rep_act[i] <= 1'b1;
                    r_rep_per[i] <= 1'b0;
                    r_rep_cnt[i] <= '0;
                end else if (!w_lr_lvl[i]) begin
                    r_rep_act[i] <= 1'b0;
                end else if (w_rep_tick[i]) begin
                    r_rep_per[i] <= 1'b1;
                    r_rep_cnt[i] <= '0;
                end else if (r_rep_act[i]) begin
                    r_rep_cnt[i] <= r_rep_cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    assign w_lr_rep = 2'b00;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_action_pulse <= 1'b0;
            r_cancel_pulse <= 1'b0;
            r_left_pulse   <= 1'b0;
            r_right_pulse  <= 1'b0;
        end else begin
            r_action_pulse <= w_press[5];
            r_cancel_pulse <= w_press[4];
            r_left_pulse   <= w_lr_ok[1] | w_lr_rep[1];
            r_right_pulse  <= w_lr_ok[0] | w_lr_rep[0];
        end
    end

    deteccion_larga #(.LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)) u_larga_reset (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_level (reset_db),
        .i_press (w_press[1]),
        .o_long  (w_reset_long)
    );

    deteccion_larga #(.LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)) u_larga_test (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_level (test_db),
        .i_press (w_press[0]),
        .o_long  (w_test_long)
    );

    // A reset long press wins over a coincident test long press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            r_test_mode <= 1'b0;
        else if (w_reset_long) r_test_mode <= 1'b0;
        else if (w_test_long)  r_test_mode <= ~r_test_mode;
    end

    assign action_pulse = r_action_pulse;
    assign cancel_pulse = r_cancel_pulse;
    assign left_pulse   = r_left_pulse;
    assign right_pulse  = r_right_pulse;
    assign reset_long   = w_reset_long;
    assign test_long    = w_test_long;
    assign test_mode    = r_test_mode;

endmodule
